// File: rtl/temple_run_pkg.sv
// Shared definitions for the temple run player stage: lane codes, one-hot moves,
// FSM state encoding and point values.
package temple_run_pkg;

  localparam logic [1:0] CODE_OBST  = 2'b00;
  localparam logic [1:0] CODE_CLEAR = 2'b01;
  localparam logic [1:0] CODE_COIN  = 2'b10;

  localparam logic [2:0] MOVE_RIGHT  = 3'b100;
  localparam logic [2:0] MOVE_CENTRE = 3'b010;
  localparam logic [2:0] MOVE_LEFT   = 3'b001;

  localparam int PTS_COIN  = 3;
  localparam int PTS_CLEAR = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ROW = 3'd1,
    DECIDE   = 3'd2,
    COMMIT   = 3'd3,
    OVER     = 3'd4
  } state_t;

  // Lane code under a one-hot lane; anything not right/left reads the centre lane.
  function automatic logic [1:0] lane_code(input logic [2:0] lane,
                                           input logic [1:0] code_r,
                                           input logic [1:0] code_c,
                                           input logic [1:0] code_l);
    logic [1:0] code;
    case (lane)
      MOVE_RIGHT: code = code_r;
      MOVE_LEFT:  code = code_l;
      default:    code = code_c;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/temple_run_runner_btn_debounce.sv
// Button front end: 2-flop synchroniser, stable-count debouncer and a
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_last;
  logic          r_level;
  logic          r_level_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta    <= 1'b0;
      r_sync    <= 1'b0;
      r_last    <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_meta    <= i_btn;
      r_sync    <= r_meta;
      r_last    <= r_sync;
      r_level_q <= r_level;
      // Any change of the synchronised sample restarts the stability count.
      if (r_sync != r_last) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_last;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_level & ~r_level_q;

endmodule

// File: rtl/temple_run_runner.sv
// Player stage: debounced lane buttons, per-row decision window, score/lives
// bookkeeping. Define TEMPLE_RUN_AUTOPILOT_EN to pick the best lane automatically.
module temple_run_runner
  import temple_run_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DECISION_CYCLES = 1000,
  parameter int MAX_LIVES       = 3,
  parameter int SCORE_W         = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_right,
  input  logic               btn_centre,
  input  logic               btn_left,
  input  logic [1:0]         path_right,
  input  logic [1:0]         path_centre,
  input  logic [1:0]         path_left,
  input  logic               row_valid,
  output logic [2:0]         move,
  output logic               move_valid,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over,
  output logic               overrun,
  output logic [2:0]         dbg_state
);
  // Handshake: row_valid is a 1-cycle pulse accepted only in WAIT_ROW; path_* stay
  // stable until move_valid, a 1-cycle pulse during COMMIT carrying the chosen lane.

  logic w_press_r, w_press_c, w_press_l, w_any_press;
  logic [2:0] w_press_lane;
  logic [1:0] w_code;
  logic [1:0] w_pts;
  logic [SCORE_W:0] w_sum;
  logic [SCORE_W-1:0] w_score_next;

  state_t             r_state;
  logic [2:0]         r_lane;
  logic [2:0]         r_move;
  logic               r_move_valid;
  logic [SCORE_W-1:0] r_score;
  logic [1:0]         r_lives;
  logic               r_game_over;
  logic               r_overrun;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst(rst), .i_btn(btn_right), .o_press(w_press_r));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_centre (
    .clk(clk), .rst(rst), .i_btn(btn_centre), .o_press(w_press_c));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst(rst), .i_btn(btn_left), .o_press(w_press_l));

  assign w_any_press  = w_press_r | w_press_c | w_press_l;
  assign w_press_lane = w_press_r ? MOVE_RIGHT : (w_press_c ? MOVE_CENTRE : MOVE_LEFT);

  assign w_code = lane_code(r_lane, path_right, path_centre, path_left);

  always_comb begin
    w_pts = 2'd0;
    case (w_code)
      CODE_COIN:         w_pts = 2'(PTS_COIN);
      CODE_CLEAR, 2'b11: w_pts = 2'(PTS_CLEAR);
      default:           w_pts = 2'd0;
    endcase
  end

  assign w_sum        = {1'b0, r_score} + (SCORE_W + 1)'(w_pts);
  assign w_score_next = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];

`ifdef TEMPLE_RUN_AUTOPILOT_EN
  function automatic logic [2:0] best_lane(input logic [1:0] c_r,
                                           input logic [1:0] c_c,
                                           input logic [1:0] c_l);
    if (c_r >= c_c && c_r >= c_l) return MOVE_RIGHT;
    else if (c_c >= c_l)          return MOVE_CENTRE;
    else                          return MOVE_LEFT;
  endfunction

  logic [2:0] w_auto_lane;
  assign w_auto_lane = best_lane(path_right, path_centre, path_left);
`else
  localparam int DW = (DECISION_CYCLES > 1) ? $clog2(DECISION_CYCLES) : 1;
  logic [DW-1:0] r_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lane       <= MOVE_CENTRE;
      r_move       <= MOVE_CENTRE;
      r_move_valid <= 1'b0;
      r_score      <= '0;
      r_lives      <= 2'(MAX_LIVES);
      r_game_over  <= 1'b0;
      r_overrun    <= 1'b0;
`ifndef TEMPLE_RUN_AUTOPILOT_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_move_valid <= 1'b0;
      if (row_valid && r_state != WAIT_ROW) r_overrun <= 1'b1;
      case (r_state)
        IDLE, OVER: begin
          if (w_any_press) begin
            r_score     <= '0;
            r_lives     <= 2'(MAX_LIVES);
            r_game_over <= 1'b0;
            r_state     <= WAIT_ROW;
          end
        end
        WAIT_ROW: begin
          if (row_valid) begin
`ifndef TEMPLE_RUN_AUTOPILOT_EN
            r_cnt <= '0;
`endif
            r_state <= DECIDE;
          end
        end
        DECIDE: begin
`ifdef TEMPLE_RUN_AUTOPILOT_EN
          r_lane       <= w_auto_lane;
          r_move       <= w_auto_lane;
          r_move_valid <= 1'b1;
          r_state      <= COMMIT;
`else
          r_cnt <= r_cnt + 1'b1;
          // A press beats the timeout when both land in the same cycle.
          if (w_any_press) begin
            r_lane       <= w_press_lane;
            r_move       <= w_press_lane;
            r_move_valid <= 1'b1;
            r_state      <= COMMIT;
          end else if (r_cnt == DW'(DECISION_CYCLES - 1)) begin
            r_move       <= r_lane;
            r_move_valid <= 1'b1;
            r_state      <= COMMIT;
          end
`endif
        end
        COMMIT: begin
          if (w_code == CODE_OBST) begin
            if (r_lives <= 2'd1) begin
              r_lives     <= 2'd0;
              r_game_over <= 1'b1;
              r_state     <= OVER;
            end else begin
              r_lives <= r_lives - 2'd1;
              r_state <= WAIT_ROW;
            end
          end else begin
            r_score <= w_score_next;
            r_state <= WAIT_ROW;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign move       = r_move;
  assign move_valid = r_move_valid;
  assign score      = r_score;
  assign lives      = r_lives;
  assign game_over  = r_game_over;
  assign overrun    = r_overrun;
  assign dbg_state  = r_state;

endmodule

// File: doc/temple_run_runner.md
Name: temple_run_runner

Overview:
Player-side stage for the temple run game. Consumes each new row of lane codes from the track generator and debounces three lane buttons. Selects a lane within a decision window and returns a one-hot move to the generator. Keeps score and lives and flags game over.

Parameters:
DEBOUNCE_CYCLES, 16, stable cycles before a button level is accepted
DECISION_CYCLES, 1000, clk cycles allowed per row before the current lane auto-commits
MAX_LIVES, 3, lives loaded at game start (1..3)
SCORE_W, 10, score width; score saturates at 2**SCORE_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
btn_right  in  1  raw asynchronous button
btn_centre  in  1  raw asynchronous button
btn_left  in  1  raw asynchronous button
path_right  in  2  lane code: 00 obstacle, 01 clear, 10 coin, 11 treated as clear
path_centre  in  2  lane code
path_left  in  2  lane code
row_valid  in  1  1-cycle pulse; path_* are stable from this cycle until the next move_valid
move  out  3  one-hot lane: 100 right, 010 centre, 001 left
move_valid  out  1  1-cycle pulse when move is committed
score  out  SCORE_W  accumulated points
lives  out  2  remaining lives
game_over  out  1  high in OVER state
overrun  out  1  sticky; row_valid arrived while not in WAIT_ROW

Behaviour:
- Reset values:
  - State IDLE; move=010; lane=centre.
  - move_valid=0; score=0; lives=MAX_LIVES; game_over=0; overrun=0.
  - Debounced levels and decision counter cleared.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer counter resets on any change and accepts the new level after DEBOUNCE_CYCLES equal samples.
  - A press is the 1-cycle rising edge of the debounced level.
- Lane priority: simultaneous presses in the same cycle resolve right > centre > left.
- IDLE:
  - Any press clears score, loads lives=MAX_LIVES and goes to WAIT_ROW.
  - Lane is unchanged.
- WAIT_ROW: row_valid goes to DECIDE on the next cycle and clears the decision counter.
- DECIDE:
  - The counter increments each cycle.
  - A press sets the lane and goes to COMMIT.
  - If the counter reaches DECISION_CYCLES-1 with no press, go to COMMIT keeping the current lane.
  - A press in the same cycle as the timeout wins.
- COMMIT (one cycle):
  - move_valid=1 and move=lane, with move registered in the same transition.
  - Code taken is the path_* value of the lane.
  - Coin: score +3. Clear or 11: score +1. Both saturate at max.
  - Obstacle: lives-1.
  - If lives would become 0, go to OVER; otherwise go to WAIT_ROW.
  - score and lives are visible the cycle after move_valid.
- OVER:
  - game_over=1; move holds.
  - Any press behaves as in IDLE, clears game_over and goes to WAIT_ROW.
- Latency:
  - row_valid at cycle N gives DECIDE at N+1.
  - A press edge at cycle M gives move_valid at M+1.
  - The earliest possible move_valid is N+2.
- row_valid outside WAIT_ROW is ignored and sets overrun. Only rst clears overrun.
- rst mid-game returns to IDLE in the next cycle regardless of state. No move_valid is emitted.

Optional Feature:
- Macro: TEMPLE_RUN_AUTOPILOT_EN.
- When defined:
  - In DECIDE, buttons are ignored for lane choice.
  - After exactly one cycle in DECIDE, the lane with the highest code is chosen, tie priority right > centre > left, and the block goes to COMMIT.
  - The IDLE and OVER start press is still required.
- When undefined: manual behaviour as above, with no autopilot logic synthesised.

Decomposition:
- Shared package temple_run_pkg holds:
  - Lane code constants CODE_OBST=2'b00, CODE_CLEAR=2'b01, CODE_COIN=2'b10.
  - Move one-hot constants MOVE_RIGHT/CENTRE/LEFT.
  - State encoding IDLE, WAIT_ROW, DECIDE, COMMIT, OVER.
  - Point values PTS_COIN=3 and PTS_CLEAR=1.
- One sub-module, btn_debounce: synchroniser plus debouncer plus rising-edge output, parameterised by DEBOUNCE_CYCLES. It is instantiated three times.

Test Plan:
- Reset, then press centre (debounced) -> WAIT_ROW; score=0, lives=3, move=010, game_over=0.
- Row {R=10,C=01,L=00}, then press right -> move_valid one cycle after the press edge; move=100; score=3 next cycle.
- Row {R=00,C=01,L=01}, no press, DECISION_CYCLES=8 -> move_valid on the 9th cycle after row_valid; move=100; lives 3->2.
- Three obstacle rows taken -> lives=0 and game_over=1; a press restarts with score=0 and lives=3.
- A 5-cycle glitch on btn_left with DEBOUNCE_CYCLES=16 -> no lane change. Right and left pressed in the same cycle -> move=100.
- row_valid pulsed while in DECIDE -> overrun=1, stays set through later rows. rst asserted in DECIDE -> IDLE, no move_valid.
